// File: rtl/_addsub_serial.sv
// Nibble-serial adder/subtractor: one 4-bit slice iterated WIDTH/4 times, LS nibble first.
// Define ADDSUB_FLAGS_EN to build the cout/ovf/zero flag logic; otherwise the flags are tied to 0.
module _addsub_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned Nsl  = WIDTH / 4;
  localparam int unsigned CntW = (Nsl > 1) ? $clog2(Nsl) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, s_q;
  logic              c_q;
  logic [CntW-1:0]   cnt_q;
  logic [4:0]        sum;
  logic              last;
  logic [WIDTH-1:0]  s_res;

  assign sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
  assign last = (cnt_q == CntW'(Nsl - 1));

  // Result with the current step's nibble merged in; on the last step this is the full result.
  always_comb begin
    s_res = s_q;
    s_res[4*int'(cnt_q) +: 4] = sum[3:0];
  end

`ifdef ADDSUB_FLAGS_EN
  logic cout_q, ovf_q, zero_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef ADDSUB_FLAGS_EN
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            c_q     <= sub_i;
            cnt_q   <= '0;
            s_q     <= '0;
`ifdef ADDSUB_FLAGS_EN
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          c_q   <= sum[4];
          s_q   <= s_res;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= StDone;
`ifdef ADDSUB_FLAGS_EN
            // On the last step a_q[3]/b_q[3] are the operand MSBs (b already inverted for sub).
            cout_q  <= sum[4];
            ovf_q   <= (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
            zero_q  <= (s_res == '0);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign s_o    = s_q;

`ifdef ADDSUB_FLAGS_EN
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;
`else
  assign cout_o = 1'b0;
  assign ovf_o  = 1'b0;
  assign zero_o = 1'b0;
`endif

endmodule

// File: tb/tb__addsub_serial.sv
// Directed bench for _addsub_serial: a 32-bit and an 8-bit instance with hand-computed results.
module tb__addsub_serial;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8, subi;
  logic [31:0] ai, bi;
  logic [7:0]  a8, b8;
  logic        busy, done, cout, ovf, zero;
  logic [31:0] s;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  s8;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  _addsub_serial #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(subi), .a_i(ai), .b_i(bi),
    .busy_o(busy), .done_o(done), .s_o(s), .cout_o(cout), .ovf_o(ovf), .zero_o(zero)
  );

  _addsub_serial #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(subi), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .s_o(s8), .cout_o(cout8), .ovf_o(ovf8), .zero_o(zero8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit sb,
                     input logic [31:0] es, input bit ec, input bit eo, input bit ez,
                     input int elat, input string tag);
    int k;
    subi = sb;
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      ai = a; bi = b; start = 1'b1;
    end
    tick();
    start  = 1'b0;
    start8 = 1'b0;
    chk({tag, "_busy"}, 32'(w8 ? busy8 : busy), 32'd1);
    k = 1;
    while (!(w8 ? done8 : done) && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, elat);
    chk({tag, "_s"}, w8 ? {24'b0, s8} : s, es);
    chk({tag, "_cout"}, 32'(w8 ? cout8 : cout), 32'(ec & FE));
    chk({tag, "_ovf"}, 32'(w8 ? ovf8 : ovf), 32'(eo & FE));
    chk({tag, "_zero"}, 32'(w8 ? zero8 : zero), 32'(ez & FE));
    tick();
    chk({tag, "_donefall"}, 32'(w8 ? done8 : done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start8 = 1'b0; subi = 1'b0;
    ai = '0; bi = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    chk("rst_flags32", {27'b0, busy, done, cout, ovf, zero}, 32'd0);
    chk("rst_s32", s, 32'd0);
    chk("rst_flags8", {27'b0, busy8, done8, cout8, ovf8, zero8}, 32'd0);
    rst = 1'b0;
    tick();

    run(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 9, "add_wrap");
    run(1'b0, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 9, "sub_5_7");
    run(1'b0, 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 9, "sub_7_5");
    run(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 9, "add_ovf");
    run(1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 9, "sub_ovf");

    // Start held high: new operands while running must be ignored, next accept right after done.
    ai = 32'h10; bi = 32'h20; subi = 1'b0; start = 1'b1;
    tick();
    ai = 32'h100; bi = 32'h200;
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("b2b_lat1", n, 9);
    chk("b2b_s1", s, 32'h30);
    tick();
    chk("b2b_done_accept", 32'(done), 32'd0);
    chk("b2b_busy_accept", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("b2b_lat2", n, 9);
    chk("b2b_s2", s, 32'h300);
    start = 1'b0;
    tick();
    chk("b2b_done_fall", 32'(done), 32'd0);
    chk("b2b_busy_fall", 32'(busy), 32'd0);

    // Abort mid-operation with an asynchronous reset.
    ai = 32'h1234_5678; bi = 32'h1111_1111; subi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_flags", {27'b0, busy, done, cout, ovf, zero}, 32'd0);
    chk("abort_s", s, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 9, "post_abort");

    run(1'b1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3, "w8_add");
    run(1'b1, 32'h10, 32'h20, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, 3, "w8_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/_addsub_serial.md
# _addsub_serial

Nibble-serial add/subtract unit built around a single 4-bit adder slice of the 74x283 kind. Handles an arbitrary multiple-of-4 operand width by iterating one nibble per clock, least significant first, with a registered carry between nibbles. Trades latency for chip count and serves as the low-cost ALU adder path in the homebrew RISC-V datapath. Uses a start/done handshake so the control sequencer can stall while it runs.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; multiple of 4 and ≥ 4; NSL = WIDTH/4 nibble steps.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when state ≠ RUN.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while state = RUN.
- done  out  1  one-cycle pulse, result valid.
- s  out  WIDTH  result; holds until next accepted start.
- cout  out  1  final carry out (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE or DONE, start=1: latch A ← a, B ← (sub ? ~b : b), C ← sub, step counter ← 0, s ← 0; → RUN.
- IDLE or DONE, start=0: DONE → IDLE; IDLE stays.
- RUN, each edge: {c4, n} = A[3:0] + B[3:0] + C (5-bit sum); place n into s nibble [4k+3:4k] for step k; C ← c4; A, B shift right 4; counter +1.
- RUN, step NSL−1 completing: → DONE; flags latched.
- start while in RUN: ignored; no effect on operands, counter or result.
- Arithmetic: modulo 2^WIDTH; sub is two's complement (A + ~B + 1).
- ovf = (a[MSB] == B'[MSB]) && (s[MSB] != a[MSB]), where B' is the effective (possibly inverted) operand; latched at completion.
- zero: registered at completion from the full result.
- rst asserted at any time, including mid-RUN: operation aborted, state → IDLE, all outputs 0, partial result discarded.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, ovf=0, zero=0.
- start accepted at edge E0; busy=1 from after E0 through edge E_NSL.
- Edges E1..E_NSL each process one nibble. After E_NSL: busy=0, done=1, s/cout/ovf/zero valid.
- done falls after E_NSL+1 unless a new start is sampled at E_NSL+1. In that case done=0 and busy=1 after that edge, giving back-to-back operations with throughput NSL+1 cycles.
- Latency: NSL+1 edges from start to done. WIDTH=32 gives 9 edges.
- s, cout, ovf, zero stay stable from done until the next accepted start.

## Configuration
- ADDSUB_FLAGS_EN defined: cout, ovf and zero computed and latched as above.
- ADDSUB_FLAGS_EN undefined: flag logic omitted. cout, ovf and zero are tied to 0. s, busy, done and latency are unchanged.

## Test plan
- WIDTH=32, flags on, a=0x00000001, b=0xFFFFFFFF, sub=0 → done 9 edges after start; s=0x00000000, cout=1, zero=1, ovf=0.
- WIDTH=32, sub=1, a=5, b=7 → s=0xFFFFFFFE, cout=0, ovf=0, zero=0; a=7, b=5 → s=2, cout=1.
- WIDTH=32, a=0x7FFFFFFF, b=1, add → s=0x80000000, ovf=1. Also a=0x80000000, b=1, sub → s=0x7FFFFFFF, ovf=1.
- Start held high continuously with a new operand set each accept → second start during RUN ignored. Results arrive every 9 cycles. done=0 on the cycle a new start is accepted.
- Assert rst at step 3 of a 32-bit add → all outputs 0 immediately. A subsequent 0x12345678+0x11111111 gives s=0x23456789 with correct 9-edge latency.
- WIDTH=8 instance, 0xFF+0x01 → s=0x00, cout=1, zero=1 after 3 edges. Repeat with ADDSUB_FLAGS_EN undefined → same s, flags 0.
